// File: rtl/turbo_punct_serializer.sv
// Turbo encoder output stage: punctures 3-bit {p2,p1,sys} symbols into 2- or 3-bit
// groups, queues them in a small FIFO and shifts them out one bit per cycle.
module turbo_punct_serializer #(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 8,
  parameter bit PUNCT_EN   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sym_valid_i,
  input  logic [2:0]                    sym_in_i,
  output logic                          sym_ready_o,
  output logic                          bit_out_o,
  output logic                          bit_valid_o,
  input  logic                          bit_ready_i,
  output logic                          frame_start_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          state_dbg_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and ready here depends only on registered state.

  logic [IW-1:0] sym_idx_q, sym_idx_d;
  logic [5:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          overflow_q;
  logic          full, empty, push, pop;
  logic [2:0]    grp_bits;
  logic [1:0]    grp_len;
  logic          grp_sof;
  logic [5:0]    rd_entry;

  state_e        state_q;
  logic [2:0]    sh_bits_q;
  logic [1:0]    sh_len_q;
  logic [1:0]    bit_ptr_q;
  logic          sh_sof_q;
  logic          last_bit;
  logic          cur_bit;

  assign full     = (count_q == LW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = sym_valid_i & ~full;
  assign rd_entry = mem_q[rd_ptr_q];
  assign last_bit = (bit_ptr_q == (sh_len_q - 2'd1));

  // Phase follows every upstream symbol, dropped or not, so puncturing stays aligned.
  always_comb begin
    sym_idx_d = sym_idx_q + IW'(1);
    if (sym_idx_q == IW'(FRAME_LEN - 1)) sym_idx_d = '0;
  end

  always_comb begin
    grp_bits = 3'b000;
    grp_len  = 2'd2;
    grp_sof  = (sym_idx_q == '0);
    if (!PUNCT_EN) begin
      grp_bits = sym_in_i;
      grp_len  = 2'd3;
    end else if (!sym_idx_q[0]) begin
      grp_bits = {1'b0, sym_in_i[1], sym_in_i[0]};
    end else begin
      grp_bits = {1'b0, sym_in_i[2], sym_in_i[0]};
    end
  end

  always_comb begin
    pop = 1'b0;
    if (state_q == S_IDLE) pop = ~empty;
    else                   pop = bit_ready_i & last_bit & ~empty;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {grp_sof, grp_len, grp_bits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sym_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + LW'(push) - LW'(pop);
      if (sym_valid_i) sym_idx_q <= sym_idx_d;
      if (sym_valid_i && full) overflow_q <= 1'b1;
    end
  end

  // Loading the next group on the last accepted bit keeps the output gap-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sh_bits_q <= 3'b000;
      sh_len_q  <= 2'd2;
      sh_sof_q  <= 1'b0;
      bit_ptr_q <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            {sh_sof_q, sh_len_q, sh_bits_q} <= rd_entry;
            bit_ptr_q <= 2'd0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_ready_i) begin
            if (!last_bit) begin
              bit_ptr_q <= bit_ptr_q + 2'd1;
            end else if (!empty) begin
              {sh_sof_q, sh_len_q, sh_bits_q} <= rd_entry;
              bit_ptr_q <= 2'd0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (bit_ptr_q)
      2'd0:    cur_bit = sh_bits_q[0];
      2'd1:    cur_bit = sh_bits_q[1];
      default: cur_bit = sh_bits_q[2];
    endcase
  end

  assign sym_ready_o   = ~full;
  assign bit_valid_o   = (state_q == S_SHIFT);
  assign bit_out_o     = (state_q == S_SHIFT) & cur_bit;
  assign frame_start_o = (state_q == S_SHIFT) & sh_sof_q & (bit_ptr_q == 2'd0);
  assign overflow_o    = overflow_q;
  assign fifo_level_o  = count_q;
  assign state_dbg_o   = (state_q == S_SHIFT);

endmodule

// File: tb/tb_turbo_punct_serializer.sv
// Bench for turbo_punct_serializer: a rate-1/2 and a rate-1/3 instance checked
// against a queue-based model of the puncturing and framing rules.
module tb_turbo_punct_serializer;

  localparam int DEPTH = 8;
  localparam int FLEN  = 8;
  localparam int LW    = 4;

  logic clk = 1'b0;
  logic rst;

  logic          sv_p, br_p, sr_p, bo_p, bv_p, fs_p, ov_p, st_p;
  logic [2:0]    si_p;
  logic [LW-1:0] lv_p;
  logic          sv_n, br_n, sr_n, bo_n, bv_n, fs_n, ov_n, st_n;
  logic [2:0]    si_n;
  logic [LW-1:0] lv_n;

  int checks = 0;
  int fails  = 0;
  int idx_p, idx_n;
  bit done;

  // Entries are {frame_start, bit}.
  logic [1:0] exp_p_q[$];
  logic [1:0] exp_n_q[$];
  logic [1:0] got_p_q[$];
  logic [1:0] got_n_q[$];

  turbo_punct_serializer #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN), .PUNCT_EN(1'b1)) u_p (
    .clk(clk), .rst(rst), .sym_valid_i(sv_p), .sym_in_i(si_p), .sym_ready_o(sr_p),
    .bit_out_o(bo_p), .bit_valid_o(bv_p), .bit_ready_i(br_p), .frame_start_o(fs_p),
    .overflow_o(ov_p), .fifo_level_o(lv_p), .state_dbg_o(st_p)
  );

  turbo_punct_serializer #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN), .PUNCT_EN(1'b0)) u_n (
    .clk(clk), .rst(rst), .sym_valid_i(sv_n), .sym_in_i(si_n), .sym_ready_o(sr_n),
    .bit_out_o(bo_n), .bit_valid_o(bv_n), .bit_ready_i(br_n), .frame_start_o(fs_n),
    .overflow_o(ov_n), .fifo_level_o(lv_n), .state_dbg_o(st_n)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    sv_p = 1'b0; sv_n = 1'b0; br_p = 1'b0; br_n = 1'b0;
    si_p = 3'b000; si_n = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idx_p = 0; idx_n = 0;
    exp_p_q.delete(); exp_n_q.delete(); got_p_q.delete(); got_n_q.delete();
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst && bv_p && br_p) got_p_q.push_back({fs_p, bo_p});
    if (!rst && bv_n && br_n) got_n_q.push_back({fs_n, bo_n});
  end

  // ---------------- reference model ----------------
  // Rate 1/2 keeps sys plus p1 on even symbol indices and p2 on odd ones;
  // rate 1/3 keeps all three bits. Frame start marks the sys bit of index 0.
  task automatic model_sym(input bit on_p, input logic [2:0] s);
    if (on_p) begin
      exp_p_q.push_back({idx_p == 0, s[0]});
      exp_p_q.push_back({1'b0, (idx_p % 2 == 0) ? s[1] : s[2]});
      idx_p = (idx_p + 1) % FLEN;
    end else begin
      exp_n_q.push_back({idx_n == 0, s[0]});
      exp_n_q.push_back({1'b0, s[1]});
      exp_n_q.push_back({1'b0, s[2]});
      idx_n = (idx_n + 1) % FLEN;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input bit on_p, input logic [2:0] s);
    int n = 0;
    while (((on_p && !sr_p) || (!on_p && !sr_n)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; fails++;
      $display("FAIL send_timeout: sym_ready=0 after 200 cycles, required 1");
    end
    if (on_p) begin sv_p = 1'b1; si_p = s; end
    else      begin sv_n = 1'b1; si_n = s; end
    model_sym(on_p, s);
    @(posedge clk); #1;
    if (on_p) sv_p = 1'b0;
    else      sv_n = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((got_p_q.size() < exp_p_q.size() || got_n_q.size() < exp_n_q.size()) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({sr_p, bv_p, ov_p, lv_p, fs_p, bo_p} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_p: ready=%b valid=%b ovf=%b lvl=%0d fs=%b bit=%b, required 1 0 0 0 0 0",
               sr_p, bv_p, ov_p, lv_p, fs_p, bo_p);
    end
    checks++;
    if ({sr_n, bv_n, ov_n, lv_n, fs_n, bo_n} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_n: ready=%b valid=%b ovf=%b lvl=%0d fs=%b bit=%b, required 1 0 0 0 0 0",
               sr_n, bv_n, ov_n, lv_n, fs_n, bo_n);
    end
    @(posedge clk); #1;
    sv_p = 1'b1; sv_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      si_p = 3'($urandom_range(0, 7));
      si_n = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    sv_p = 1'b0; sv_n = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sr_p, bv_p, ov_p, lv_p, fs_p, bo_p} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midreset_p: ready=%b valid=%b ovf=%b lvl=%0d fs=%b bit=%b, required 1 0 0 0 0 0",
               sr_p, bv_p, ov_p, lv_p, fs_p, bo_p);
    end
    checks++;
    if ({sr_n, bv_n, ov_n, lv_n, fs_n, bo_n} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midreset_n: ready=%b valid=%b ovf=%b lvl=%0d fs=%b bit=%b, required 1 0 0 0 0 0",
               sr_n, bv_n, ov_n, lv_n, fs_n, bo_n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_punct();
    logic [2:0] syms [4];
    syms[0] = 3'b011; syms[1] = 3'b101; syms[2] = 3'b111; syms[3] = 3'b000;
    do_reset();
    br_p = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, syms[i]);
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (got_p_q.size() !== exp_p_q.size()) begin
      fails++;
      $display("FAIL punct_count: got %0d bits, required %0d", got_p_q.size(), exp_p_q.size());
    end
    for (int i = 0; i < exp_p_q.size() && i < got_p_q.size(); i++) begin
      checks++;
      if (got_p_q[i] !== exp_p_q[i]) begin
        fails++;
        $display("FAIL punct_bit[%0d]: got fs,bit=%b, required %b", i, got_p_q[i], exp_p_q[i]);
      end
    end
  endtask

  task automatic test_rate13_latency();
    do_reset();
    br_n = 1'b1;
    sv_n = 1'b1; si_n = 3'b110;
    model_sym(1'b0, 3'b110);
    @(posedge clk); #1;
    sv_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bv_n !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: bit_valid=%b one cycle after accept, required 0", bv_n);
    end
    @(negedge clk);
    checks++;
    if ({bv_n, fs_n, bo_n} !== 3'b110) begin
      fails++;
      $display("FAIL r13_bit0: valid,fs,bit=%b, required 110", {bv_n, fs_n, bo_n});
    end
    @(negedge clk);
    checks++;
    if ({bv_n, fs_n, bo_n} !== 3'b101) begin
      fails++;
      $display("FAIL r13_bit1: valid,fs,bit=%b, required 101", {bv_n, fs_n, bo_n});
    end
    @(negedge clk);
    checks++;
    if ({bv_n, fs_n, bo_n} !== 3'b101) begin
      fails++;
      $display("FAIL r13_bit2: valid,fs,bit=%b, required 101", {bv_n, fs_n, bo_n});
    end
    @(negedge clk);
    checks++;
    if ({bv_n, fs_n, bo_n} !== 3'b000) begin
      fails++;
      $display("FAIL r13_idle: valid,fs,bit=%b, required 000", {bv_n, fs_n, bo_n});
    end
    @(posedge clk); #1;
    checks++;
    if (got_n_q.size() !== exp_n_q.size()) begin
      fails++;
      $display("FAIL r13_count: got %0d bits, required %0d", got_n_q.size(), exp_n_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [2:0] s;
    do_reset();
    br_p = 1'b0;
    // With the consumer stalled, one group sits in the shifter and DEPTH in the FIFO.
    for (int i = 0; i < 11; i++) begin
      s = 3'($urandom_range(0, 7));
      sv_p = 1'b1; si_p = s;
      if (i < DEPTH + 1) model_sym(1'b1, s);
      else               idx_p = (idx_p + 1) % FLEN;
      if (i == DEPTH + 1) begin
        @(negedge clk);
        checks++;
        if ({lv_p, sr_p, ov_p} !== {4'd8, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL full_state: lvl=%0d ready=%b ovf=%b, required 8 0 0", lv_p, sr_p, ov_p);
        end
      end
      @(posedge clk); #1;
    end
    sv_p = 1'b0;
    @(negedge clk);
    checks++;
    if ({lv_p, ov_p} !== {4'd8, 1'b1}) begin
      fails++;
      $display("FAIL drop_state: lvl=%0d ovf=%b, required 8 1", lv_p, ov_p);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ov_p !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b, required 1", ov_p);
    end
    br_p = 1'b1;
    drain();
    send(1'b1, 3'($urandom_range(0, 7)));
    drain();
    checks++;
    if ({lv_p, ov_p} !== {4'd0, 1'b1}) begin
      fails++;
      $display("FAIL after_drain: lvl=%0d ovf=%b, required 0 1", lv_p, ov_p);
    end
    checks++;
    if (got_p_q.size() !== exp_p_q.size()) begin
      fails++;
      $display("FAIL ovf_count: got %0d bits, required %0d", got_p_q.size(), exp_p_q.size());
    end
    for (int i = 0; i < exp_p_q.size() && i < got_p_q.size(); i++) begin
      checks++;
      if (got_p_q[i] !== exp_p_q[i]) begin
        fails++;
        $display("FAIL ovf_bit[%0d]: got fs,bit=%b, required %b", i, got_p_q[i], exp_p_q[i]);
      end
    end
  endtask

  task automatic test_frames();
    do_reset();
    br_p = 1'b1;
    for (int i = 0; i < 17; i++) send(1'b1, 3'($urandom_range(0, 7)));
    drain();
    checks++;
    if (got_p_q.size() !== 34) begin
      fails++;
      $display("FAIL frame_count: got %0d bits, required 34", got_p_q.size());
    end
    for (int i = 0; i < exp_p_q.size() && i < got_p_q.size(); i++) begin
      checks++;
      if (got_p_q[i] !== exp_p_q[i] || got_p_q[i][1] !== (i % 16 == 0)) begin
        fails++;
        $display("FAIL frame_bit[%0d]: got fs,bit=%b, required %b", i, got_p_q[i], exp_p_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    br_p = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 3'($urandom_range(0, 7)));
    repeat (2) @(posedge clk);
    #1;
    br_p = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bv_p, fs_p, bo_p} !== {1'b1, exp_p_q[i]}) begin
        fails++;
        $display("FAIL b2b_bit[%0d]: valid,fs,bit=%b, required %b", i, {bv_p, fs_p, bo_p}, {1'b1, exp_p_q[i]});
      end
    end
    @(negedge clk);
    checks++;
    if (bv_p !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: bit_valid=%b, required 0", bv_p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] hold_p, hold_n;
    bit         held_p, held_n;
    do_reset();
    done = 1'b0; held_p = 1'b0; held_n = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            send(1'b1, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
          for (int i = 0; i < 30; i++) begin
            send(1'b0, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
        join
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        br_p = 1'($urandom_range(0, 1));
        br_n = 1'($urandom_range(0, 1));
      end
      while (!done) begin
        @(negedge clk);
        if (held_p) begin
          checks++;
          if ({bv_p, fs_p, bo_p} !== hold_p) begin
            fails++;
            $display("FAIL stall_hold_p: valid,fs,bit=%b, required %b", {bv_p, fs_p, bo_p}, hold_p);
          end
        end
        if (held_n) begin
          checks++;
          if ({bv_n, fs_n, bo_n} !== hold_n) begin
            fails++;
            $display("FAIL stall_hold_n: valid,fs,bit=%b, required %b", {bv_n, fs_n, bo_n}, hold_n);
          end
        end
        held_p = bv_p && !br_p; hold_p = {bv_p, fs_p, bo_p};
        held_n = bv_n && !br_n; hold_n = {bv_n, fs_n, bo_n};
      end
    join
    br_p = 1'b1; br_n = 1'b1;
    drain();
    checks++;
    if (got_p_q.size() !== exp_p_q.size() || got_n_q.size() !== exp_n_q.size()) begin
      fails++;
      $display("FAIL rand_count: got %0d/%0d bits, required %0d/%0d",
               got_p_q.size(), got_n_q.size(), exp_p_q.size(), exp_n_q.size());
    end
    for (int i = 0; i < exp_p_q.size() && i < got_p_q.size(); i++) begin
      checks++;
      if (got_p_q[i] !== exp_p_q[i]) begin
        fails++;
        $display("FAIL rand_p_bit[%0d]: got fs,bit=%b, required %b", i, got_p_q[i], exp_p_q[i]);
      end
    end
    for (int i = 0; i < exp_n_q.size() && i < got_n_q.size(); i++) begin
      checks++;
      if (got_n_q[i] !== exp_n_q[i]) begin
        fails++;
        $display("FAIL rand_n_bit[%0d]: got fs,bit=%b, required %b", i, got_n_q[i], exp_n_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    sv_p = 1'b0; sv_n = 1'b0; br_p = 1'b0; br_n = 1'b0;
    si_p = 3'b000; si_n = 3'b000;
    test_reset();
    test_punct();
    test_rate13_latency();
    test_overflow();
    test_frames();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
